// File: rtl/pe_mac_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_acc_if
// Brief    : Operand-in / result-out bundle between the A/B load stage, the
//            PE multiply-accumulate stage and the result collector.
// Revision : 1.0 - initial release
// ============================================================================
interface pe_mac_acc_if #(
    parameter int D_WIDTH    = 64,
    parameter int ACC_WIDTH  = 64,
    parameter int ADDR_WIDTH = 2
);
    logic [D_WIDTH-1:0]    data_A_in;
    logic [D_WIDTH-1:0]    data_B_in;
    logic                  valid_AB_in;
    logic                  busy_out;
    logic [ACC_WIDTH-1:0]  data_C_out;
    logic [ADDR_WIDTH-1:0] addr_C_out;
    logic                  valid_C_out;
    logic                  ready_C_in;
    logic                  done_out;
    logic                  err_drop_out;

    modport master (
        output data_A_in, data_B_in, valid_AB_in, ready_C_in,
        input  busy_out, data_C_out, addr_C_out, valid_C_out, done_out, err_drop_out
    );

    modport slave (
        input  data_A_in, data_B_in, valid_AB_in, ready_C_in,
        output busy_out, data_C_out, addr_C_out, valid_C_out, done_out, err_drop_out
    );
endinterface
`default_nettype wire

// File: rtl/pe_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_acc
// Brief    : PE compute stage: multiply-accumulates operand pairs into a local
//            C buffer over K_NUM passes, then drains it as a valid/ready stream.
//            Optional macro MAC_SAT_EN: saturating k>0 accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac_acc #(
    parameter int D_WIDTH   = 64,
    parameter int ACC_WIDTH = 64,
    parameter int PE_NUM    = 2,
    parameter int B_NUM     = 2,
    parameter int K_NUM     = 2
) (
    input  logic        clk,
    input  logic        rst,
    pe_mac_acc_if.slave bus
);
    localparam int c_DEPTH = PE_NUM * B_NUM;
    localparam int c_AW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int c_PW    = c_AW + 1;
    localparam int c_IW    = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int c_JW    = (B_NUM > 1) ? $clog2(B_NUM) : 1;
    localparam int c_KW    = (K_NUM > 1) ? $clog2(K_NUM) : 1;

    localparam logic [c_IW-1:0] c_I_MAX     = c_IW'(PE_NUM - 1);
    localparam logic [c_JW-1:0] c_J_MAX     = c_JW'(B_NUM - 1);
    localparam logic [c_KW-1:0] c_K_MAX     = c_KW'(K_NUM - 1);
    localparam logic [c_AW-1:0] c_ADDR_LAST = c_AW'(c_DEPTH - 1);
    localparam logic [c_PW-1:0] c_PTR_END   = c_PW'(c_DEPTH);

    generate
        if (c_DEPTH < 2) begin : g_bad_depth
            $error("pe_mac_acc: PE_NUM*B_NUM must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IW-1:0]      r_i;
    logic [c_JW-1:0]      r_j;
    logic [c_KW-1:0]      r_k;
    logic                 r_busy, r_done, r_err;

    logic                 r_v1, r_v2, r_v3;
    logic [D_WIDTH-1:0]   r_a, r_b;
    logic [c_AW-1:0]      r_addr1, r_addr2, r_addr3;
    logic                 r_first1, r_first2, r_first3;
    logic                 r_last1, r_last2, r_last3;
    logic [ACC_WIDTH-1:0] r_prod2, r_prod3;

    logic [ACC_WIDTH-1:0] r_mem [0:(1<<c_AW)-1];
    logic [ACC_WIDTH-1:0] r_rdata;

    logic [c_PW-1:0]      r_ptr;
    logic                 r_rv;
    logic [c_AW-1:0]      r_raddr;
    logic                 r_valid_c;
    logic [ACC_WIDTH-1:0] r_data_c;
    logic [c_AW-1:0]      r_addr_c;

    logic                        w_accept, w_last_pair;
    logic [c_AW-1:0]             w_addr_in, w_rd_addr;
    logic                        w_out_acc, w_issue, w_last_hs, w_rd_en;
    logic signed [2*D_WIDTH-1:0] w_prod_full;
    logic [ACC_WIDTH-1:0]        w_prod, w_acc, w_wr_data;

    assign w_accept    = bus.valid_AB_in && (r_state != ST_DRAIN);
    assign w_last_pair = (r_i == c_I_MAX) && (r_j == c_J_MAX) && (r_k == c_K_MAX);
    assign w_addr_in   = c_AW'(int'(r_j) * PE_NUM + int'(r_i));

    assign w_prod_full = $signed(r_a) * $signed(r_b);

    generate
        if (ACC_WIDTH <= 2*D_WIDTH) begin : g_prod_trunc
            assign w_prod = w_prod_full[ACC_WIDTH-1:0];
            if (ACC_WIDTH < 2*D_WIDTH) begin : g_prod_unused
                logic w_unused_prod_msbs;
                assign w_unused_prod_msbs = ^w_prod_full[2*D_WIDTH-1:ACC_WIDTH];
            end
        end else begin : g_prod_sext
            assign w_prod = {{(ACC_WIDTH-2*D_WIDTH){w_prod_full[2*D_WIDTH-1]}}, w_prod_full};
        end
    endgenerate

`ifdef MAC_SAT_EN
    logic [ACC_WIDTH:0] w_sum_ext;
    always_comb begin
        w_sum_ext = {r_rdata[ACC_WIDTH-1], r_rdata} + {r_prod3[ACC_WIDTH-1], r_prod3};
        // Differing top two bits of the extended sum flag a signed overflow.
        if (w_sum_ext[ACC_WIDTH] != w_sum_ext[ACC_WIDTH-1])
            w_acc = w_sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            w_acc = w_sum_ext[ACC_WIDTH-1:0];
    end
`else
    assign w_acc = r_rdata + r_prod3;
`endif

    assign w_wr_data = r_first3 ? r_prod3 : w_acc;

    // Single read port: accumulate reads in ACC/IDLE, stream reads in DRAIN.
    assign w_out_acc = !r_valid_c || bus.ready_C_in;
    assign w_issue   = (r_state == ST_DRAIN) && (r_ptr < c_PTR_END) && (!r_rv || w_out_acc);
    assign w_last_hs = r_valid_c && bus.ready_C_in && (r_addr_c == c_ADDR_LAST);
    assign w_rd_en   = (r_state == ST_DRAIN) ? w_issue : (r_v2 && !r_first2);
    assign w_rd_addr = (r_state == ST_DRAIN) ? r_ptr[c_AW-1:0] : r_addr2;

    always_ff @(posedge clk) begin
        if (r_v3)
            r_mem[r_addr3] <= w_wr_data;
        if (w_rd_en)
            r_rdata <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
            r_a <= '0; r_b <= '0;
            r_addr1 <= '0; r_addr2 <= '0; r_addr3 <= '0;
            r_first1 <= 1'b0; r_first2 <= 1'b0; r_first3 <= 1'b0;
            r_last1 <= 1'b0; r_last2 <= 1'b0; r_last3 <= 1'b0;
            r_prod2 <= '0; r_prod3 <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_a      <= bus.data_A_in;
                r_b      <= bus.data_B_in;
                r_addr1  <= w_addr_in;
                r_first1 <= (r_k == '0);
                r_last1  <= w_last_pair;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prod2  <= w_prod;
                r_addr2  <= r_addr1;
                r_first2 <= r_first1;
                r_last2  <= r_last1;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_prod3  <= r_prod2;
                r_addr3  <= r_addr2;
                r_first3 <= r_first2;
                r_last3  <= r_last2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_i <= '0; r_j <= '0; r_k <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
            r_ptr <= '0; r_rv <= 1'b0; r_raddr <= '0;
            r_valid_c <= 1'b0; r_data_c <= '0; r_addr_c <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == ST_DRAIN) && bus.valid_AB_in)
                r_err <= 1'b1;

            if (w_accept) begin
                if (r_i == c_I_MAX) begin
                    r_i <= '0;
                    if (r_j == c_J_MAX) begin
                        r_j <= '0;
                        r_k <= (r_k == c_K_MAX) ? '0 : r_k + 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end

            if (w_issue) begin
                r_ptr   <= r_ptr + 1'b1;
                r_raddr <= r_ptr[c_AW-1:0];
                r_rv    <= 1'b1;
            end else if (w_out_acc) begin
                r_rv    <= 1'b0;
            end

            if (w_out_acc) begin
                r_valid_c <= r_rv;
                if (r_rv) begin
                    r_data_c <= r_rdata;
                    r_addr_c <= r_raddr;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept)
                        r_state <= ST_ACC;
                end
                ST_ACC: begin
                    if (r_v3 && r_last3) begin
                        r_state <= ST_DRAIN;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_hs) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_out     = r_busy;
    assign bus.done_out     = r_done;
    assign bus.err_drop_out = r_err;
    assign bus.valid_C_out  = r_valid_c;
    assign bus.data_C_out   = r_data_c;
    assign bus.addr_C_out   = r_addr_c;
endmodule
`default_nettype wire

// File: tb/tb_pe_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_mac_acc
// Brief    : Self-checking bench for pe_mac_acc (2x2x2, 16-bit) plus an 8-bit
//            accumulator instance for the overflow case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_mac_acc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_mac_acc_if #(.D_WIDTH(16), .ACC_WIDTH(16), .ADDR_WIDTH(2)) bus ();
    pe_mac_acc_if #(.D_WIDTH(16), .ACC_WIDTH(8),  .ADDR_WIDTH(2)) bus8 ();

    pe_mac_acc #(.D_WIDTH(16), .ACC_WIDTH(16), .PE_NUM(2), .B_NUM(2), .K_NUM(2))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));
    pe_mac_acc #(.D_WIDTH(16), .ACC_WIDTH(8), .PE_NUM(2), .B_NUM(2), .K_NUM(2))
        dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int n_assert = 0;
    int n_fail   = 0;

    logic signed [15:0] mA [2][2];   // A[i][k]
    logic signed [15:0] mB [2][2];   // B[k][j]
    logic [15:0]        exp_c [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic longint s16(input longint x);
        logic signed [15:0] t;
        t = x[15:0];
        return longint'(t);
    endfunction

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], each product truncated to 16 bits.
    task automatic build_expected();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                longint acc;
                acc = 0;
                for (int k = 0; k < 2; k++) begin
                    longint p;
                    p = s16(longint'(mA[i][k]) * longint'(mB[k][j]));
                    if (k == 0) acc = p;
                    else begin
                        acc = acc + p;
`ifdef MAC_SAT_EN
                        if (acc > 32767)  acc = 32767;
                        if (acc < -32768) acc = -32768;
`else
                        acc = s16(acc);
`endif
                    end
                end
                exp_c[j*2+i] = acc[15:0];
            end
        end
    endtask

    task automatic rand_job();
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                mA[a][b] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
                mB[a][b] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
            end
        build_expected();
    endtask

    // Streams pairs in k, j, i order (i fastest); valid asserted once every 'gap' cycles.
    task automatic send_job(input int gap, input int npairs);
        int p;
        p = 0;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                for (int i = 0; i < 2; i++) begin
                    if (p < npairs) begin
                        for (int g = 1; g < gap; g++) begin
                            bus.valid_AB_in = 1'b0;
                            @(posedge clk); #1;
                        end
                        bus.valid_AB_in = 1'b1;
                        bus.data_A_in   = mA[i][k];
                        bus.data_B_in   = mB[k][j];
                        @(posedge clk); #1;
                        if (p == 0) check("done_pulse_width", bus.done_out, 1'b0);
                        p++;
                    end
                end
        bus.valid_AB_in = 1'b0;
    endtask

    // Starts one cycle after the last pair edge; ends 4 cycles later.
    task automatic wait_drain();
        check("busy_before_drain", bus.busy_out, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("busy_before_drain", bus.busy_out, 1'b0);
        end
        @(posedge clk); #1;
        check("busy_enter_drain", bus.busy_out, 1'b1);
        check("valid_c_early", bus.valid_C_out, 1'b0);
        @(posedge clk); #1;
        check("valid_c_early", bus.valid_C_out, 1'b0);
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready.
    task automatic collect(input int mode, input int inject_at);
        int got, cyc, first, last;
        logic rdy, stalled;
        logic [15:0] hd;
        logic [1:0]  ha;
        got = 0; cyc = 0; first = -1; last = -1; stalled = 1'b0; hd = '0; ha = '0;
        while (got < 4 && cyc < 100) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.ready_C_in  = rdy;
            bus.valid_AB_in = (cyc == inject_at);
            bus.data_A_in   = 16'($urandom);
            bus.data_B_in   = 16'($urandom);
            if (bus.valid_C_out) begin
                if (first < 0) first = cyc;
                if (stalled) begin
                    check("hold_data", bus.data_C_out, hd);
                    check("hold_addr", bus.addr_C_out, ha);
                end
                if (rdy) begin
                    check("addr_seq", bus.addr_C_out, got[1:0]);
                    check("result_data", bus.data_C_out, exp_c[got]);
                    got++;
                    last = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hd = bus.data_C_out;
                    ha = bus.addr_C_out;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.valid_AB_in = 1'b0;
        check("drain_word_count", got, 4);
        check("valid_c_latency", first, 1);
        if (mode == 0) check("drain_rate_span", last - first, 3);
        check("done_pulse", bus.done_out, 1'b1);
        check("busy_fall", bus.busy_out, 1'b0);
        check("valid_c_after_last", bus.valid_C_out, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        logic [7:0] exp8;

        rst = 1'b1;
        bus.data_A_in = '0; bus.data_B_in = '0; bus.valid_AB_in = 1'b0; bus.ready_C_in = 1'b0;
        bus8.data_A_in = '0; bus8.data_B_in = '0; bus8.valid_AB_in = 1'b0; bus8.ready_C_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  bus.busy_out, 1'b0);
        check("rst_valid", bus.valid_C_out, 1'b0);
        check("rst_done",  bus.done_out, 1'b0);
        check("rst_err",   bus.err_drop_out, 1'b0);
        check("rst_data",  bus.data_C_out, 16'h0);
        check("rst_addr",  bus.addr_C_out, 2'h0);
        rst = 1'b0;
        bus.ready_C_in = 1'b1;
        @(posedge clk); #1;

        // Identity A with B[k][j] = 10k+j+1
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                mA[a][b] = (a == b) ? 16'sd1 : 16'sd0;
                mB[a][b] = 16'(10 * a + b + 1);
            end
        build_expected();
        send_job(1, 8); wait_drain(); collect(0, -1);

        // Same job, back-to-back, under backpressure
        send_job(1, 8); wait_drain(); collect(1, -1);

        // Gapped input
        send_job(3, 8); wait_drain(); collect(0, -1);

        // Pair injected during drain
        send_job(1, 8); wait_drain(); collect(0, 2);
        check("err_drop_set", bus.err_drop_out, 1'b1);
        rand_job();
        send_job(1, 8); wait_drain(); collect(2, -1);
        check("err_drop_sticky", bus.err_drop_out, 1'b1);

        for (int n = 0; n < 3; n++) begin
            rand_job();
            send_job(int'($urandom_range(1, 2)), 8); wait_drain(); collect(2, -1);
        end

        // Reset after five pairs, then a fresh job of all 2 x 3
        rand_job();
        send_job(1, 5);
        rst = 1'b1;
        #1;
        check("async_rst_err",   bus.err_drop_out, 1'b0);
        check("async_rst_busy",  bus.busy_out, 1'b0);
        check("async_rst_valid", bus.valid_C_out, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_hold_data", bus.data_C_out, 16'h0);
        check("rst_hold_done", bus.done_out, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) begin
                mA[a][b] = 16'sd2;
                mB[a][b] = 16'sd3;
            end
        build_expected();
        send_job(1, 8); wait_drain(); collect(0, -1);

        // Overflow on the 8-bit accumulator instance: 100 + 100
`ifdef MAC_SAT_EN
        exp8 = 8'h7F;
`else
        exp8 = 8'hC8;
`endif
        for (int p = 0; p < 8; p++) begin
            bus8.valid_AB_in = 1'b1;
            bus8.data_A_in   = 16'd100;
            bus8.data_B_in   = 16'd1;
            @(posedge clk); #1;
        end
        bus8.valid_AB_in = 1'b0;
        bus8.ready_C_in  = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (bus8.valid_C_out) begin
                check("ovf_addr", bus8.addr_C_out, got[1:0]);
                check("ovf_data", bus8.data_C_out, exp8);
                got++;
            end
            @(posedge clk); #1;
        end
        check("ovf_word_count", got, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
